// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB command arbiter.
// Optional feature macro: APB_ARB_RR_EN (round-robin tie breaking).
package apb_arb_pkg;

   localparam int unsigned NUM_REQ            = 2;
   localparam int unsigned DEF_DATA_WIDTH     = 32;
   localparam int unsigned DEF_ADDRESS_WIDTH  = 4;
   localparam int unsigned DEF_STRB_WIDTH     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/apb_rr_picker.sv
// Two-way request picker.
// With APB_ARB_RR_EN defined a tie goes to the requester not served last and a
// one-bit pointer remembers the last winner; otherwise requester 0 always wins a
// tie and no pointer exists.
module apb_rr_picker (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       take,
   output logic       winner
);

`ifdef APB_ARB_RR_EN
   logic last_q;

   // Remember the last served requester at every accepted grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (take && (|req)) begin
         last_q <= winner;
      end
   end

   // Tie goes to the requester that was not served last.
   always_comb begin
      winner = req[1];
      if (req == 2'b11) begin
         winner = ~last_q;
      end
   end
`else
   // Clock, reset and take are only needed by the pointer.
   logic unused_ptr_inputs;
   assign unused_ptr_inputs = clk ^ rst_n ^ take;

   // Requester 0 has fixed priority.
   always_comb begin
      winner = ~req[0] & req[1];
   end
`endif

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates two request ports onto a single APB_MASTER command interface.
// One transfer in flight at a time: IDLE -> WAIT (grant, command issued) ->
// RESP (one-cycle completion pulse) -> IDLE.
// Optional feature macro: APB_ARB_RR_EN (round-robin tie breaking in the picker).
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int unsigned STRB_WIDTH    = DEF_STRB_WIDTH
) (
   input  logic                            PCLK,
   input  logic                            PRESETn,
   input  logic [NUM_REQ-1:0]              REQ_VALID,
   input  logic [NUM_REQ-1:0]              REQ_WRITE,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] REQ_ADDR,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_WDATA,
   input  logic [NUM_REQ*STRB_WIDTH-1:0]   REQ_STRB,
   output logic [NUM_REQ-1:0]              REQ_GNT,
   output logic [NUM_REQ-1:0]              RSP_VALID,
   output logic [DATA_WIDTH-1:0]           RSP_RDATA,
   output logic                            RSP_SLVERR,
   output logic                            Transfer,
   output logic [ADDRESS_WIDTH-1:0]        IN_ADDR,
   output logic [DATA_WIDTH-1:0]           IN_DATA,
   output logic                            IN_WRITE,
   output logic [STRB_WIDTH-1:0]           IN_STRB,
   input  logic                            PENABLE,
   input  logic                            PREADY,
   input  logic [DATA_WIDTH-1:0]           OUT_RDATA,
   input  logic                            OUT_SLVERR
);

   arb_state_e state_q, state_d;

   logic                     owner_q;
   logic                     gnt_q;
   logic [ADDRESS_WIDTH-1:0] in_addr_q;
   logic [DATA_WIDTH-1:0]    in_data_q;
   logic                     in_write_q;
   logic [STRB_WIDTH-1:0]    in_strb_q;

   logic winner;
   logic take;
   logic apb_done;

   assign take     = (state_q == IDLE) && (|REQ_VALID);
   assign apb_done = PENABLE & PREADY;

   apb_rr_picker u_picker (
      .clk    (PCLK),
      .rst_n  (PRESETn),
      .req    (REQ_VALID),
      .take   (take),
      .winner (winner)
   );

   // State register.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: grant from IDLE, wait for the APB access to complete, report once.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|REQ_VALID) state_d = WAIT;
         WAIT:    if (apb_done)   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture the winner's command at grant; it stays put until the next grant.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         owner_q    <= 1'b0;
         gnt_q      <= 1'b0;
         in_addr_q  <= '0;
         in_data_q  <= '0;
         in_write_q <= 1'b0;
         in_strb_q  <= '0;
      end else begin
         gnt_q <= take;
         if (take) begin
            owner_q    <= winner;
            in_write_q <= REQ_WRITE[winner];
            in_addr_q  <= winner ? REQ_ADDR[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                                 : REQ_ADDR[ADDRESS_WIDTH-1:0];
            in_data_q  <= winner ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : REQ_WDATA[DATA_WIDTH-1:0];
            in_strb_q  <= winner ? REQ_STRB[2*STRB_WIDTH-1:STRB_WIDTH]
                                 : REQ_STRB[STRB_WIDTH-1:0];
         end
      end
   end

   // Outputs; Transfer drops as soon as the access completes so no second transfer starts.
   always_comb begin
      Transfer   = (state_q == WAIT) & ~apb_done;
      REQ_GNT    = '0;
      RSP_VALID  = '0;
      RSP_RDATA  = '0;
      RSP_SLVERR = 1'b0;
      if (gnt_q) begin
         REQ_GNT = owner_q ? 2'b10 : 2'b01;
      end
      if (state_q == RESP) begin
         RSP_VALID  = owner_q ? 2'b10 : 2'b01;
         RSP_SLVERR = OUT_SLVERR;
         if (!in_write_q) begin
            RSP_RDATA = OUT_RDATA;
         end
      end
   end

   assign IN_ADDR  = in_addr_q;
   assign IN_DATA  = in_data_q;
   assign IN_WRITE = in_write_q;
   assign IN_STRB  = in_strb_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter with a transaction-level reference
// model and an emulated APB_MASTER with programmable wait states.
// Expected tie-break order follows APB_ARB_RR_EN when defined.
module tb_apb_req_arbiter;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int SW = 4;

   logic            PCLK;
   logic            PRESETn;
   logic [1:0]      REQ_VALID;
   logic [1:0]      REQ_WRITE;
   logic [2*AW-1:0] REQ_ADDR;
   logic [2*DW-1:0] REQ_WDATA;
   logic [2*SW-1:0] REQ_STRB;
   logic [1:0]      REQ_GNT;
   logic [1:0]      RSP_VALID;
   logic [DW-1:0]   RSP_RDATA;
   logic            RSP_SLVERR;
   logic            Transfer;
   logic [AW-1:0]   IN_ADDR;
   logic [DW-1:0]   IN_DATA;
   logic            IN_WRITE;
   logic [SW-1:0]   IN_STRB;
   logic            PENABLE;
   logic            PREADY;
   logic [DW-1:0]   OUT_RDATA;
   logic            OUT_SLVERR;

   int errors = 0;
   int checks = 0;

   apb_req_arbiter #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .STRB_WIDTH    (SW)
   ) dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .REQ_VALID  (REQ_VALID),
      .REQ_WRITE  (REQ_WRITE),
      .REQ_ADDR   (REQ_ADDR),
      .REQ_WDATA  (REQ_WDATA),
      .REQ_STRB   (REQ_STRB),
      .REQ_GNT    (REQ_GNT),
      .RSP_VALID  (RSP_VALID),
      .RSP_RDATA  (RSP_RDATA),
      .RSP_SLVERR (RSP_SLVERR),
      .Transfer   (Transfer),
      .IN_ADDR    (IN_ADDR),
      .IN_DATA    (IN_DATA),
      .IN_WRITE   (IN_WRITE),
      .IN_STRB    (IN_STRB),
      .PENABLE    (PENABLE),
      .PREADY     (PREADY),
      .OUT_RDATA  (OUT_RDATA),
      .OUT_SLVERR (OUT_SLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Emulated APB_MASTER: setup phase, then access with wait_cfg PREADY-low cycles.
   int am;
   int wcnt;
   int wait_cfg;
   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         am      <= 0;
         wcnt    <= 0;
         PENABLE <= 1'b0;
         PREADY  <= 1'b0;
      end else begin
         case (am)
            0: if (Transfer) am <= 1;
            1: begin
               am      <= 2;
               PENABLE <= 1'b1;
               PREADY  <= (wait_cfg == 0);
               wcnt    <= wait_cfg;
            end
            default: begin
               if (PREADY) begin
                  am      <= 0;
                  PENABLE <= 1'b0;
                  PREADY  <= 1'b0;
               end else begin
                  wcnt   <= wcnt - 1;
                  PREADY <= (wcnt == 1);
               end
            end
         endcase
      end
   end

   // Reference model: one transaction at a time, tie rule from the configuration.
   logic            m_busy, m_resp, m_gnt, m_owner, m_last, m_write;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata;
   logic [SW-1:0]   m_strb;

   function automatic logic pick(input logic [1:0] req, input logic last);
      if (req == 2'b11) begin
`ifdef APB_ARB_RR_EN
         return ~last;
`else
         return 1'b0;
`endif
      end
      return (req == 2'b10);
   endfunction

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         m_busy  <= 1'b0;
         m_resp  <= 1'b0;
         m_gnt   <= 1'b0;
         m_owner <= 1'b0;
         m_last  <= 1'b1;
         m_write <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_strb  <= '0;
      end else begin
         m_gnt <= 1'b0;
         if (m_resp) begin
            m_resp <= 1'b0;
            m_busy <= 1'b0;
         end else if (m_busy) begin
            if (PENABLE && PREADY) m_resp <= 1'b1;
         end else if (|REQ_VALID) begin
            m_busy  <= 1'b1;
            m_gnt   <= 1'b1;
            m_owner <= pick(REQ_VALID, m_last);
            m_last  <= pick(REQ_VALID, m_last);
            m_write <= REQ_WRITE[pick(REQ_VALID, m_last)];
            m_addr  <= REQ_ADDR[pick(REQ_VALID, m_last)*AW +: AW];
            m_wdata <= REQ_WDATA[pick(REQ_VALID, m_last)*DW +: DW];
            m_strb  <= REQ_STRB[pick(REQ_VALID, m_last)*SW +: SW];
         end
      end
   end

   // Compare every output against the model on every falling edge.
   always @(negedge PCLK) begin
      logic [1:0] oh;
      oh = m_owner ? 2'b10 : 2'b01;
      check("gnt", REQ_GNT, m_gnt ? oh : 2'b00);
      check("rsp_valid", RSP_VALID, m_resp ? oh : 2'b00);
      check("rsp_rdata", RSP_RDATA, (m_resp && !m_write) ? OUT_RDATA : '0);
      check("rsp_slverr", RSP_SLVERR, m_resp ? OUT_SLVERR : 1'b0);
      check("transfer", Transfer, m_busy && !m_resp && !(PENABLE && PREADY));
      check("in_addr", IN_ADDR, m_addr);
      check("in_data", IN_DATA, m_wdata);
      check("in_write", IN_WRITE, m_write);
      check("in_strb", IN_STRB, m_strb);
   end

   task automatic set_req(input int idx, input logic v, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
      REQ_VALID[idx]         = v;
      REQ_WRITE[idx]         = wr;
      REQ_ADDR[idx*AW +: AW] = a;
      REQ_WDATA[idx*DW +: DW] = d;
      REQ_STRB[idx*SW +: SW] = s;
   endtask

   task automatic do_reset();
      @(negedge PCLK);
      #2;
      PRESETn = 1'b0;
      repeat (2) @(negedge PCLK);
      #2;
      PRESETn = 1'b1;
   endtask

   // One request, held until granted; reports edges to response, Transfer-high cycles,
   // IN_ADDR at grant and the response fields.
   task automatic run_single(input int idx, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s, input int waits,
                             input logic [DW-1:0] rdata, input logic slverr, output int lat,
                             output int tcnt, output logic [AW-1:0] gaddr,
                             output logic [DW-1:0] rsp_d, output logic rsp_e);
      bit got;
      got  = 0;
      lat  = 0;
      tcnt = 0;
      gaddr = '0;
      rsp_d = '0;
      rsp_e = 1'b0;
      @(negedge PCLK);
      #2;
      OUT_RDATA  = rdata;
      OUT_SLVERR = slverr;
      wait_cfg   = waits;
      set_req(idx, 1'b1, wr, a, d, s);
      for (int c = 0; c < 40 && !got; c++) begin
         @(posedge PCLK);
         lat++;
         @(negedge PCLK);
         if (Transfer) tcnt++;
         if (REQ_GNT[idx]) begin
            gaddr = IN_ADDR;
            REQ_VALID[idx] = 1'b0;
         end
         if (RSP_VALID[idx]) begin
            got   = 1;
            rsp_d = RSP_RDATA;
            rsp_e = RSP_SLVERR;
         end
      end
      check("rsp_timeout", got, 1'b1);
      REQ_VALID[idx] = 1'b0;
   endtask

   initial begin
      int lat, tcnt, ng, nrsp;
      logic [AW-1:0] gaddr;
      logic [DW-1:0] rd;
      logic          er;
      int grants[4];
      int exp_g[4];

      PRESETn    = 1'b0;
      REQ_VALID  = '0;
      REQ_WRITE  = '0;
      REQ_ADDR   = '0;
      REQ_WDATA  = '0;
      REQ_STRB   = '0;
      OUT_RDATA  = '0;
      OUT_SLVERR = 1'b0;
      wait_cfg   = 0;
      repeat (2) @(negedge PCLK);
      check("reset_gnt", REQ_GNT, 2'b00);
      check("reset_transfer", Transfer, 1'b0);
      #2;
      PRESETn = 1'b1;
      repeat (2) @(negedge PCLK);

      // Single write from requester 0, no wait states.
      run_single(0, 1'b1, 4'hF, 32'd240, 4'hF, 0, 32'h0, 1'b0, lat, tcnt, gaddr, rd, er);
      check("wr_latency", lat, 4);
      check("wr_in_addr", gaddr, 4'hF);
      check("wr_transfer_cycles", tcnt, 2);
      check("wr_slverr", er, 1'b0);
      check("wr_rdata", rd, 32'h0);
      repeat (2) @(negedge PCLK);

      // Read from requester 1 with three PREADY-low access cycles.
      run_single(1, 1'b0, 4'h1, 32'h0, 4'h0, 3, 32'd15, 1'b0, lat, tcnt, gaddr, rd, er);
      check("rd_latency", lat, 7);
      check("rd_transfer_cycles", tcnt, 5);
      check("rd_rdata", rd, 32'd15);
      check("rd_in_addr", gaddr, 4'h1);
      repeat (2) @(negedge PCLK);

      // Slave error reported only during the response cycle.
      run_single(0, 1'b1, 4'h7, 32'hDEAD_BEEF, 4'h3, 1, 32'h55, 1'b1, lat, tcnt, gaddr, rd, er);
      check("err_slverr", er, 1'b1);
      check("err_latency", lat, 5);
      @(negedge PCLK);
      check("err_slverr_after", RSP_SLVERR, 1'b0);
      OUT_SLVERR = 1'b0;
      repeat (2) @(negedge PCLK);

      // Both requesters valid continuously from a fresh reset.
      do_reset();
      @(negedge PCLK);
      #2;
      wait_cfg = 0;
      set_req(0, 1'b1, 1'b1, 4'h2, 32'h1111_0000, 4'h1);
      set_req(1, 1'b1, 1'b0, 4'h9, 32'h2222_0000, 4'h8);
      ng = 0;
      for (int c = 0; c < 100 && ng < 4; c++) begin
         @(negedge PCLK);
         if (REQ_GNT != 2'b00) begin
            grants[ng] = REQ_GNT[1] ? 1 : 0;
            ng++;
         end
      end
      REQ_VALID = '0;
      check("tie_grant_count", ng, 4);
`ifdef APB_ARB_RR_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif
      for (int i = 0; i < 4; i++) check($sformatf("tie_grant%0d", i), grants[i], exp_g[i]);
      repeat (6) @(negedge PCLK);

      // Reset in WAIT aborts the transfer; first tie afterwards goes to requester 0.
      @(negedge PCLK);
      #2;
      wait_cfg = 5;
      set_req(1, 1'b1, 1'b1, 4'hC, 32'hCAFE_F00D, 4'hF);
      ng = 0;
      for (int c = 0; c < 20 && ng == 0; c++) begin
         @(negedge PCLK);
         if (REQ_GNT[1]) ng = 1;
      end
      check("abort_granted", ng, 1);
      REQ_VALID = '0;
      repeat (2) @(negedge PCLK);
      check("abort_in_wait", Transfer, 1'b1);
      #2;
      PRESETn = 1'b0;
      #1;
      check("abort_transfer", Transfer, 1'b0);
      check("abort_gnt", REQ_GNT, 2'b00);
      check("abort_rsp", RSP_VALID, 2'b00);
      check("abort_in_addr", IN_ADDR, 4'h0);
      check("abort_in_data", IN_DATA, 32'h0);
      repeat (2) @(negedge PCLK);
      #2;
      PRESETn = 1'b1;
      nrsp = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge PCLK);
         if (RSP_VALID != 2'b00) nrsp++;
      end
      check("abort_no_rsp", nrsp, 0);
      #2;
      wait_cfg = 0;
      set_req(0, 1'b1, 1'b0, 4'h3, 32'h0, 4'h0);
      set_req(1, 1'b1, 1'b0, 4'h4, 32'h0, 4'h0);
      ng = 0;
      for (int c = 0; c < 20 && ng == 0; c++) begin
         @(negedge PCLK);
         if (REQ_GNT != 2'b00) begin
            ng = 1;
            check("post_reset_tie", REQ_GNT, 2'b01);
         end
      end
      check("post_reset_granted", ng, 1);
      REQ_VALID = '0;
      repeat (6) @(negedge PCLK);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
